// File: rtl/pc_branch_unit_if.sv
// Control/fetch bundle between the multicycle datapath controller and pc_branch_unit.
// The master modport is the controller/memory side. The slave modport is the branch unit.
interface pc_branch_unit_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [1:0]       op;
  logic             br_en;
  logic [31:0]      b_imm;
  logic [31:0]      j_imm;
  logic [31:0]      i_imm;
  logic [31:0]      rs1;
  logic             busy;
  logic             done;
  logic             misalign;
  logic [31:0]      pc_out;
  logic [31:0]      link;
  logic             fetch_valid;
  logic [31:0]      fetch_addr;
  logic             fetch_ready;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output start, op, br_en, b_imm, j_imm, i_imm, rs1, fetch_ready,
    input  busy, done, misalign, pc_out, link, fetch_valid, fetch_addr,
           br_cnt, taken_cnt
  );

  modport slave (
    input  start, op, br_en, b_imm, j_imm, i_imm, rs1, fetch_ready,
    output busy, done, misalign, pc_out, link, fetch_valid, fetch_addr,
           br_cnt, taken_cnt
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Next-PC resolution for seq/branch/jal/jalr. Owns the PC and issues the next fetch.
// done lands 2 cycles after start. The fetch request is held until fetch_ready, and start is ignored while busy.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  pc_branch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [1:0]       OP_SEQ  = 2'b00;
  localparam logic [1:0]       OP_BR   = 2'b01;
  localparam logic [1:0]       OP_JAL  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      pc_q;
  logic [31:0]      link_q;
  logic             done_q;
  logic             misalign_q;
  logic [1:0]       op_q;
  logic [31:0]      b_imm_q;
  logic [31:0]      j_imm_q;
  logic [31:0]      i_imm_q;
  logic [31:0]      rs1_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic [31:0]      pc_plus4;
  logic [31:0]      jalr_sum;
  logic [31:0]      target;
  logic             target_misaligned;

  assign pc_plus4 = pc_q + 32'd4;
  assign jalr_sum = rs1_q + i_imm_q;

  always_comb begin
    target = pc_plus4;
    case (op_q)
      OP_SEQ:  target = pc_plus4;
      OP_BR:   target = bus.br_en ? (pc_q + b_imm_q) : pc_plus4;
      OP_JAL:  target = pc_q + j_imm_q;
      default: target = jalr_sum & ~32'h1;
    endcase
  end

  assign target_misaligned = (target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = EVAL;
      EVAL:    state_d = target_misaligned ? IDLE : ISSUE;
      ISSUE:   if (bus.fetch_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ISSUE;
      pc_q        <= RESET_PC;
      link_q      <= 32'h0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      op_q        <= OP_SEQ;
      b_imm_q     <= 32'h0;
      j_imm_q     <= 32'h0;
      i_imm_q     <= 32'h0;
      rs1_q       <= 32'h0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      if (state_q == IDLE && bus.start) begin
        op_q    <= bus.op;
        b_imm_q <= bus.b_imm;
        j_imm_q <= bus.j_imm;
        i_imm_q <= bus.i_imm;
        rs1_q   <= bus.rs1;
      end
      if (state_q == EVAL) begin
        done_q     <= 1'b1;
        misalign_q <= target_misaligned;
        link_q     <= pc_plus4;
        // A misaligned target is reported but never committed to the PC.
        if (!target_misaligned) pc_q <= target;
        if (op_q == OP_BR) begin
          if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_ONE;
          if (bus.br_en && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.misalign    = misalign_q;
  assign bus.pc_out      = pc_q;
  assign bus.link        = link_q;
  assign bus.fetch_valid = (state_q == ISSUE);
  assign bus.fetch_addr  = pc_q;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboarded bench: a wide-counter instance and a CNT_W=2 instance run in lockstep on shared stimulus.
module tb_pc_branch_unit;

  localparam logic [31:0] RST_PC = 32'h6000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        br_en = 1'b0;
  logic [31:0] b_imm = 32'h0;
  logic [31:0] j_imm = 32'h0;
  logic [31:0] i_imm = 32'h0;
  logic [31:0] rs1 = 32'h0;
  logic        fetch_ready = 1'b0;

  pc_branch_unit_if #(.CNT_W(32)) ifa ();
  pc_branch_unit_if #(.CNT_W(2))  ifb ();

  assign ifa.start = start;        assign ifb.start = start;
  assign ifa.op = op;              assign ifb.op = op;
  assign ifa.br_en = br_en;        assign ifb.br_en = br_en;
  assign ifa.b_imm = b_imm;        assign ifb.b_imm = b_imm;
  assign ifa.j_imm = j_imm;        assign ifb.j_imm = j_imm;
  assign ifa.i_imm = i_imm;        assign ifb.i_imm = i_imm;
  assign ifa.rs1 = rs1;            assign ifb.rs1 = rs1;
  assign ifa.fetch_ready = fetch_ready;
  assign ifb.fetch_ready = fetch_ready;

  pc_branch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pc_branch_unit #(.RESET_PC(RST_PC), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] link;
    logic        mis;
    logic [31:0] br_a;
    logic [31:0] tk_a;
    logic [1:0]  br_b;
    logic [1:0]  tk_b;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_br_a, m_tk_a;
  logic [1:0]  m_br_b, m_tk_b;
  logic        last_mis;
  logic [31:0] wrap_imm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && ifa.done) begin
      chk("sb_depth", sb.size(), 1);
      chk("b_done", {31'b0, ifb.done}, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", ifa.pc_out, e.pc);
        chk("link", ifa.link, e.link);
        chk("misalign", {31'b0, ifa.misalign}, {31'b0, e.mis});
        chk("br_cnt_a", ifa.br_cnt, e.br_a);
        chk("taken_cnt_a", ifa.taken_cnt, e.tk_a);
        chk("br_cnt_b", {30'b0, ifb.br_cnt}, {30'b0, e.br_b});
        chk("taken_cnt_b", {30'b0, ifb.taken_cnt}, {30'b0, e.tk_b});
        chk("pc_b", ifb.pc_out, e.pc);
      end
    end
  end

  task automatic do_reset();
    start = 1'b0;
    fetch_ready = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    chk("rst_done", {31'b0, ifa.done}, 0);
    rst = 1'b1;
    m_pc = RST_PC;
    m_br_a = 0; m_tk_a = 0; m_br_b = 0; m_tk_b = 0;
    sb.delete();
    step();
    chk("rst_fetch_valid", {31'b0, ifa.fetch_valid}, 1);
    chk("rst_fetch_addr", ifa.fetch_addr, RST_PC);
    chk("rst_pc", ifa.pc_out, RST_PC);
    chk("rst_busy", {31'b0, ifa.busy}, 1);
    chk("rst_link", ifa.link, 0);
    chk("rst_misalign", {31'b0, ifa.misalign}, 0);
    chk("rst_br_cnt", ifa.br_cnt, 0);
    chk("rst_taken_cnt", ifa.taken_cnt, 0);
    chk("rst_taken_cnt_b", {30'b0, ifb.taken_cnt}, 0);
  endtask

  task automatic fetch_accept();
    chk("fa_valid", {31'b0, ifa.fetch_valid}, 1);
    chk("fa_addr", ifa.fetch_addr, m_pc);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    chk("fa_idle", {31'b0, ifa.busy}, 0);
    chk("fa_no_valid", {31'b0, ifa.fetch_valid}, 0);
  endtask

  task automatic resolve(input logic [1:0] o, input logic be, input logic [31:0] bi,
                         input logic [31:0] ji, input logic [31:0] ii, input logic [31:0] r1);
    exp_t e;
    logic [31:0] tgt;
    chk("start_idle", {31'b0, ifa.busy}, 0);
    op = o; br_en = be; b_imm = bi; j_imm = ji; i_imm = ii; rs1 = r1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("eval_busy", {31'b0, ifa.busy}, 1);
    chk("eval_no_done", {31'b0, ifa.done}, 0);
    case (o)
      2'b00:   tgt = m_pc + 32'd4;
      2'b01:   tgt = be ? (m_pc + bi) : (m_pc + 32'd4);
      2'b10:   tgt = m_pc + ji;
      default: tgt = (r1 + ii) & 32'hFFFF_FFFE;
    endcase
    e.link = m_pc + 32'd4;
    e.mis  = (tgt[1:0] != 2'b00);
    if (!e.mis) m_pc = tgt;
    e.pc = m_pc;
    if (o == 2'b01) begin
      if (m_br_a != 32'hFFFF_FFFF) m_br_a++;
      if (m_br_b != 2'b11) m_br_b++;
      if (be) begin
        if (m_tk_a != 32'hFFFF_FFFF) m_tk_a++;
        if (m_tk_b != 2'b11) m_tk_b++;
      end
    end
    e.br_a = m_br_a; e.tk_a = m_tk_a; e.br_b = m_br_b; e.tk_b = m_tk_b;
    sb.push_back(e);
    last_mis = e.mis;
    step();
    chk("lat_done", {31'b0, ifa.done}, 1);
    if (e.mis) begin
      chk("mis_no_fetch", {31'b0, ifa.fetch_valid}, 0);
      chk("mis_idle", {31'b0, ifa.busy}, 0);
    end else begin
      chk("issue_valid", {31'b0, ifa.fetch_valid}, 1);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic be, input logic [31:0] bi,
                     input logic [31:0] ji, input logic [31:0] ii, input logic [31:0] r1);
    resolve(o, be, bi, ji, ii, r1);
    if (!last_mis) fetch_accept();
  endtask

  initial begin
    last_mis = 1'b0;
    do_reset();
    fetch_accept();

    run(2'b10, 1'b0, 0, 32'h10, 0, 0);
    run(2'b01, 1'b1, 32'hFFFF_FFF0, 0, 0, 0);
    run(2'b10, 1'b0, 0, 32'h10, 0, 0);
    run(2'b01, 1'b0, 32'hFFFF_FFF0, 0, 0, 0);
    run(2'b01, 1'b1, 32'h2, 0, 0, 0);
    run(2'b01, 1'b0, 32'h2, 0, 0, 0);
    run(2'b11, 1'b0, 0, 0, 32'h0, 32'h6000_1003);
    run(2'b11, 1'b0, 0, 0, 32'h0, 32'h6000_0201);
    run(2'b11, 1'b0, 0, 0, 32'hFFFF_FFFC, 32'h6000_0300);
    run(2'b00, 1'b0, 0, 0, 0, 0);
    wrap_imm = 32'hFFFF_FFFC - m_pc;
    run(2'b10, 1'b0, 0, wrap_imm, 0, 0);
    run(2'b00, 1'b0, 0, 0, 0, 0);
    chk("wrap_pc", ifa.pc_out, 32'h0);

    for (int k = 0; k < 4; k++) run(2'b01, 1'b1, 32'h8, 0, 0, 0);
    chk("sat_taken_b", {30'b0, ifb.taken_cnt}, 32'd3);
    chk("sat_br_b", {30'b0, ifb.br_cnt}, 32'd3);
    chk("taken_a", ifa.taken_cnt, m_tk_a);

    resolve(2'b00, 1'b0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; op = 2'b10; j_imm = 32'h100; br_en = 1'b1;
      step();
      chk("stall_valid", {31'b0, ifa.fetch_valid}, 1);
      chk("stall_addr", ifa.fetch_addr, m_pc);
      chk("stall_no_done", {31'b0, ifa.done}, 0);
    end
    start = 1'b0;
    do_reset();
    fetch_accept();
    run(2'b01, 1'b1, 32'h20, 0, 0, 0);
    chk("post_rst_pc", ifa.pc_out, RST_PC + 32'h20);

    step();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
